// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: host-side debug/loader command engine.
// Decodes WRITE/READ/HALT/RUN command bytes from the UART receiver, runs
// single-byte transactions on the system bus, and returns read data via
// the UART transmitter. Optional build macro UART_CMD_ACK_EN makes WRITE,
// HALT and RUN echo their opcode back as an acknowledge byte.
module uart_cmd_responder #(
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int TIMEOUT_W      = 21
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_active,
    input  logic        tx_done,
    output logic        bus_req,
    output logic        bus_we,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    input  logic        bus_ack,
    input  logic [7:0]  bus_rdata,
    output logic        cpu_halt,
    output logic        err_overrun,
    output logic        err_timeout
);

    typedef enum logic [2:0] {
        IDLE,
        GET_AH,
        GET_AL,
        GET_D,
        BUS,
        TX_GO,
        TX_WAIT
    } state_t;

    localparam logic [7:0] OP_WRITE    = 8'h02;
    localparam logic [7:0] OP_READ     = 8'h03;
    localparam logic [7:0] OP_HALT     = 8'h06;
    localparam logic [7:0] OP_RUN      = 8'h07;
    // Byte returned for a READ issued while the CPU still owns the bus.
    localparam logic [7:0] GATED_RDATA = 8'hFF;
    localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    state_t               state_q;
    state_t               state_d;
    logic                 cmd_we_q;
    logic [15:0]          addr_q;
    logic [7:0]           wdata_q;
    logic [7:0]           tx_data_q;
    logic                 halt_q;
    logic                 ovr_q;
    logic                 to_q;
    logic [TIMEOUT_W-1:0] to_cnt_q;

    logic                 ld_op;
    logic                 ld_ah;
    logic                 ld_al;
    logic                 ld_d;
    logic                 ld_tx;
    logic [7:0]           tx_val;
    logic                 halt_set;
    logic                 halt_clr;
    logic                 ovr_set;
    logic                 to_set;
    logic                 tx_start_c;
    logic                 in_get;
    logic                 expire;

    // The inter-byte timer only runs while a command is partially received.
    assign in_get = (state_q == GET_AH) || (state_q == GET_AL) || (state_q == GET_D);
    // Last idle cycle allowed; a byte arriving in this same cycle still wins.
    assign expire = (to_cnt_q == TO_LAST);

    // Next-state and datapath load decisions.
    always_comb begin
        state_d    = state_q;
        ld_op      = 1'b0;
        ld_ah      = 1'b0;
        ld_al      = 1'b0;
        ld_d       = 1'b0;
        ld_tx      = 1'b0;
        tx_val     = 8'h00;
        halt_set   = 1'b0;
        halt_clr   = 1'b0;
        ovr_set    = 1'b0;
        to_set     = 1'b0;
        tx_start_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        OP_WRITE, OP_READ: begin
                            ld_op   = 1'b1;
                            state_d = GET_AH;
                        end
                        OP_HALT: begin
                            halt_set = 1'b1;
`ifdef UART_CMD_ACK_EN
                            ld_tx    = 1'b1;
                            tx_val   = OP_HALT;
                            state_d  = TX_GO;
`endif
                        end
                        OP_RUN: begin
                            halt_clr = 1'b1;
`ifdef UART_CMD_ACK_EN
                            ld_tx    = 1'b1;
                            tx_val   = OP_RUN;
                            state_d  = TX_GO;
`endif
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end

            GET_AH: begin
                if (rx_valid) begin
                    ld_ah   = 1'b1;
                    state_d = GET_AL;
                end else if (expire) begin
                    to_set  = 1'b1;
                    state_d = IDLE;
                end
            end

            GET_AL: begin
                if (rx_valid) begin
                    ld_al = 1'b1;
                    if (cmd_we_q) begin
                        state_d = GET_D;
                    end else if (halt_q) begin
                        state_d = BUS;
                    end else begin
                        // CPU owns the bus: answer without touching it.
                        ld_tx   = 1'b1;
                        tx_val  = GATED_RDATA;
                        state_d = TX_GO;
                    end
                end else if (expire) begin
                    to_set  = 1'b1;
                    state_d = IDLE;
                end
            end

            GET_D: begin
                if (rx_valid) begin
                    ld_d = 1'b1;
                    if (halt_q) begin
                        state_d = BUS;
                    end else begin
`ifdef UART_CMD_ACK_EN
                        ld_tx   = 1'b1;
                        tx_val  = OP_WRITE;
                        state_d = TX_GO;
`else
                        state_d = IDLE;
`endif
                    end
                end else if (expire) begin
                    to_set  = 1'b1;
                    state_d = IDLE;
                end
            end

            BUS: begin
                ovr_set = rx_valid;
                if (bus_ack) begin
                    if (cmd_we_q) begin
`ifdef UART_CMD_ACK_EN
                        ld_tx   = 1'b1;
                        tx_val  = OP_WRITE;
                        state_d = TX_GO;
`else
                        state_d = IDLE;
`endif
                    end else begin
                        ld_tx   = 1'b1;
                        tx_val  = bus_rdata;
                        state_d = TX_GO;
                    end
                end
            end

            TX_GO: begin
                ovr_set = rx_valid;
                if (!tx_active) begin
                    tx_start_c = 1'b1;
                    state_d    = TX_WAIT;
                end
            end

            TX_WAIT: begin
                ovr_set = rx_valid;
                if (tx_done) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Inter-byte idle counter; cleared by any received byte or outside GET states.
    always_ff @(posedge clk) begin
        if (!rst) begin
            to_cnt_q <= '0;
        end else if (rx_valid || !in_get || expire) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

    // Command fields and transmit byte; these drive outputs so they clear on reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cmd_we_q  <= 1'b0;
            addr_q    <= 16'h0000;
            wdata_q   <= 8'h00;
            tx_data_q <= 8'h00;
        end else begin
            if (ld_op) cmd_we_q       <= (rx_data == OP_WRITE);
            if (ld_ah) addr_q[15:8]   <= rx_data;
            if (ld_al) addr_q[7:0]    <= rx_data;
            if (ld_d)  wdata_q        <= rx_data;
            if (ld_tx) tx_data_q      <= tx_val;
        end
    end

    // CPU hold flag and sticky error flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            halt_q <= 1'b0;
            ovr_q  <= 1'b0;
            to_q   <= 1'b0;
        end else begin
            if (halt_set)      halt_q <= 1'b1;
            else if (halt_clr) halt_q <= 1'b0;
            if (ovr_set)       ovr_q  <= 1'b1;
            if (to_set)        to_q   <= 1'b1;
        end
    end

    assign bus_req     = (state_q == BUS);
    assign bus_we      = cmd_we_q;
    assign bus_addr    = addr_q;
    assign bus_wdata   = wdata_q;
    assign tx_start    = tx_start_c;
    assign tx_data     = tx_data_q;
    assign cpu_halt    = halt_q;
    assign err_overrun = ovr_q;
    assign err_timeout = to_q;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Scoreboard bench for uart_cmd_responder: a byte-stream protocol model
// predicts bus transactions and transmitted bytes; independent monitors
// compare the DUT's bus and UART activity against the queued predictions.
module tb_uart_cmd_responder;

    localparam int T      = 64;
    localparam int TW     = 7;
    localparam int SETTLE = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_active;
    logic        tx_done;
    logic        bus_req;
    logic        bus_we;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_ack;
    logic [7:0]  bus_rdata;
    logic        cpu_halt;
    logic        err_overrun;
    logic        err_timeout;

    always #5 clk = ~clk;

    uart_cmd_responder #(.TIMEOUT_CYCLES(T), .TIMEOUT_W(TW)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_start(tx_start), .tx_data(tx_data), .tx_active(tx_active), .tx_done(tx_done),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .cpu_halt(cpu_halt),
        .err_overrun(err_overrun), .err_timeout(err_timeout)
    );

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } bus_t;

    int   checks = 0;
    int   errors = 0;
    bus_t exp_bus[$];
    logic [7:0] exp_tx[$];
    logic [7:0] slave_mem [0:65535];
    logic [7:0] shadow    [0:65535];
    logic hold_ack = 1'b0;

    // protocol-level reference state
    int          m_phase;
    logic [7:0]  m_op;
    logic [7:0]  m_ah;
    logic [15:0] m_addr;
    logic        m_halt, m_ovr, m_to;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_halt = 1'b0; m_ovr = 1'b0; m_to = 1'b0;
    endtask

    // Interpret one host byte; returns 1 when the DUT will do bus/UART work.
    function automatic bit model_byte(input logic [7:0] b, input int gap);
        bit   busy;
        bus_t e;
        busy = 1'b0;
        if (m_phase != 0 && gap >= T) begin
            m_phase = 0;
            m_to    = 1'b1;
        end
        case (m_phase)
            0: begin
                if (b == 8'h02 || b == 8'h03) begin
                    m_op = b; m_phase = 1;
                end else if (b == 8'h06 || b == 8'h07) begin
                    m_halt = (b == 8'h06);
`ifdef UART_CMD_ACK_EN
                    exp_tx.push_back(b);
                    busy = 1'b1;
`endif
                end
            end
            1: begin
                m_ah = b; m_phase = 2;
            end
            2: begin
                m_addr = {m_ah, b};
                if (m_op == 8'h03) begin
                    m_phase = 0;
                    busy    = 1'b1;
                    if (m_halt) begin
                        e.we = 1'b0; e.addr = m_addr; e.wdata = 8'h00;
                        exp_bus.push_back(e);
                        exp_tx.push_back(shadow[m_addr]);
                    end else begin
                        exp_tx.push_back(8'hFF);
                    end
                end else begin
                    m_phase = 3;
                end
            end
            default: begin
                m_phase = 0;
                if (m_halt) begin
                    e.we = 1'b1; e.addr = m_addr; e.wdata = b;
                    exp_bus.push_back(e);
                    shadow[m_addr] = b;
                    busy = 1'b1;
                end
`ifdef UART_CMD_ACK_EN
                exp_tx.push_back(8'h02);
                busy = 1'b1;
`endif
            end
        endcase
        return busy;
    endfunction

    // Called at a negedge: one-cycle rx_valid strobe.
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic check_flags();
        check("cpu_halt", cpu_halt, m_halt);
        check("err_overrun", err_overrun, m_ovr);
        check("err_timeout", err_timeout, m_to);
    endtask

    task automatic do_byte(input logic [7:0] b, input int g);
        bit busy;
        repeat (g) @(negedge clk);
        busy = model_byte(b, g);
        send_byte(b);
        if (busy) repeat (SETTLE) @(negedge clk);
        check_flags();
    endtask

    // Bus slave: memory with random ack latency; hold_ack stalls completion.
    initial begin
        int d;
        bus_ack = 1'b0; bus_rdata = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (bus_req) begin
                d = $urandom_range(0, 5);
                while (bus_req && (d > 0 || hold_ack)) begin
                    @(posedge clk); #1;
                    if (d > 0) d--;
                end
                if (bus_req) begin
                    bus_rdata = slave_mem[bus_addr];
                    if (bus_we) slave_mem[bus_addr] = bus_wdata;
                    bus_ack = 1'b1;
                    @(posedge clk); #1;
                    bus_ack = 1'b0;
                end
            end
        end
    end

    // UART transmitter stand-in, with random unrelated busy bursts.
    initial begin
        tx_active = 1'b0; tx_done = 1'b0;
        @(posedge clk); #1;
        forever begin
            if (tx_start) begin
                @(posedge clk); #1;
                tx_active = 1'b1;
                repeat ($urandom_range(1, 6)) begin @(posedge clk); #1; end
                tx_done = 1'b1;
                @(posedge clk); #1;
                tx_done = 1'b0; tx_active = 1'b0;
            end else if (!tx_active && $urandom_range(0, 7) == 0) begin
                tx_active = 1'b1;
                repeat ($urandom_range(1, 4)) begin @(posedge clk); #1; end
                tx_active = 1'b0;
                #1;
            end else begin
                @(posedge clk); #1;
            end
        end
    end

    // Output monitor: pops predictions whenever the DUT presents a transaction.
    initial begin
        logic prev_req, prev_ack, prev_start;
        bus_t cur, e;
        prev_req = 1'b0; prev_ack = 1'b0; prev_start = 1'b0; cur = '0;
        forever begin
            @(negedge clk);
            if (prev_ack) check("bus_req_drop_after_ack", bus_req, 1'b0);
            if (bus_req && !prev_req) begin
                if (exp_bus.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL bus_unexpected: got request at 0x%0h, expected none", bus_addr);
                end else begin
                    e = exp_bus.pop_front();
                    check("bus_we", bus_we, e.we);
                    check("bus_addr", bus_addr, e.addr);
                    if (e.we) check("bus_wdata", bus_wdata, e.wdata);
                end
                cur = {bus_we, bus_addr, bus_wdata};
            end else if (bus_req) begin
                check("bus_fields_stable", {bus_we, bus_addr, bus_wdata}, cur);
            end
            if (tx_start) begin
                if (prev_start) begin
                    checks++; errors++;
                    $display("FAIL tx_start_width: got 2+ cycles, expected 1");
                end else if (exp_tx.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL tx_unexpected: got byte 0x%0h, expected none", tx_data);
                end else begin
                    check("tx_data", tx_data, exp_tx.pop_front());
                end
            end
            prev_req = bus_req; prev_ack = bus_ack; prev_start = tx_start;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  bytes [4];
        logic [15:0] a;
        int          nb, kind, r;
        rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        for (int i = 0; i < 65536; i++) begin
            slave_mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'hA5;
            shadow[i]    = slave_mem[i];
        end
        slave_mem[16'h0123] = 8'h5A;
        shadow[16'h0123]    = 8'h5A;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_bus_req", bus_req, 1'b0);
        check("rst_bus_we", bus_we, 1'b0);
        check("rst_bus_addr", bus_addr, 16'h0000);
        check("rst_bus_wdata", bus_wdata, 8'h00);
        check("rst_tx_start", tx_start, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check_flags();
        rst = 1'b1;
        @(negedge clk);

        // HALT, write, read, gated read, address extremes
        do_byte(8'h06, 0);
        do_byte(8'h02, 0); do_byte(8'h80, 0); do_byte(8'h00, 0); do_byte(8'h4C, 0);
        do_byte(8'h03, 0); do_byte(8'h01, 0); do_byte(8'h23, 0);
        do_byte(8'h07, 0);
        do_byte(8'h03, 0); do_byte(8'h20, 0); do_byte(8'h07, 0);
        do_byte(8'h02, 1); do_byte(8'h10, 0); do_byte(8'h00, 0); do_byte(8'h99, 0);
        do_byte(8'h06, 0);
        do_byte(8'h02, 0); do_byte(8'hFF, 0); do_byte(8'hFF, 0); do_byte(8'hC3, 0);
        do_byte(8'h03, 0); do_byte(8'hFF, 0); do_byte(8'hFF, 0);
        do_byte(8'h03, 0); do_byte(8'h00, 0); do_byte(8'h00, 0);
        do_byte(8'h55, 0);

        // gaps of T-1 survive; a gap of T aborts and the next byte is an opcode
        do_byte(8'h02, 0); do_byte(8'h80, T - 1); do_byte(8'h01, T - 1); do_byte(8'h77, T - 1);
        do_byte(8'h07, 0);
        do_byte(8'h02, 0); do_byte(8'h80, 0);
        do_byte(8'h06, T);

        // overrun while the bus is stalled
        hold_ack = 1'b1;
        do_byte(8'h03, 0); do_byte(8'h01, 0); do_byte(8'h23, 0);
        check("bus_held_for_overrun", bus_req, 1'b1);
        m_ovr = 1'b1;
        send_byte(8'h07);
        hold_ack = 1'b0;
        repeat (SETTLE) @(negedge clk);
        check_flags();

        // reset in the middle of a bus cycle
        hold_ack = 1'b1;
        do_byte(8'h03, 0); do_byte(8'h44, 0); do_byte(8'h55, 0);
        check("bus_held_for_reset", bus_req, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        model_reset();
        exp_tx.delete();
        check("reset_drops_bus_req", bus_req, 1'b0);
        check_flags();
        hold_ack = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (SETTLE) @(negedge clk);

        // random command stream
        for (int n = 0; n < 250; n++) begin
            a = 16'($urandom);
            if ($urandom_range(0, 7) == 0) a = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'h0000;
            kind = $urandom_range(0, 9);
            case (kind)
                0: begin bytes[0] = 8'h06; nb = 1; end
                1: begin bytes[0] = 8'h07; nb = 1; end
                2, 3, 4: begin
                    bytes[0] = 8'h02; bytes[1] = a[15:8]; bytes[2] = a[7:0];
                    bytes[3] = 8'($urandom); nb = 4;
                end
                5, 6, 7: begin
                    bytes[0] = 8'h03; bytes[1] = a[15:8]; bytes[2] = a[7:0]; nb = 3;
                end
                default: begin
                    bytes[0] = 8'($urandom);
                    while (bytes[0] == 8'h02 || bytes[0] == 8'h03 ||
                           bytes[0] == 8'h06 || bytes[0] == 8'h07)
                        bytes[0] = 8'($urandom);
                    nb = 1;
                end
            endcase
            for (int k = 0; k < nb; k++) begin
                r = $urandom_range(0, 24);
                do_byte(bytes[k], (r == 0) ? T - 1 : (r == 1) ? T : $urandom_range(0, 3));
            end
        end

        repeat (T + 10) @(negedge clk);
        if (m_phase != 0) begin
            m_phase = 0;
            m_to    = 1'b1;
        end
        check_flags();
        check("exp_bus_drained", exp_bus.size(), 0);
        check("exp_tx_drained", exp_tx.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_cmd_responder.md
Name:
uart_cmd_responder

Overview:
- FPGA-side end of the host UART debug/loader command protocol.
- Parses command bytes from the uart_rx receiver and issues single-byte transactions on the system memory bus (CPU space and PPU registers via 0x2006/0x2007).
- Returns read data through the UART_TX transmitter and holds or releases the CPU so the bus is free for host access.
- Sits between the UART pair and the sys-ctrl bus mux inside nes_fpga_top_lvl.

Parameters:
- TIMEOUT_CYCLES, 1048576: idle clk cycles allowed between bytes of one command before it is aborted.
- TIMEOUT_W, 21: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock (25 MHz domain).
- rst  in  1  synchronous, active-low reset.
- rx_valid  in  1  one-cycle strobe, rx_data valid.
- rx_data  in  8  received byte.
- tx_start  out  1  one-cycle pulse starting transmission of tx_data.
- tx_data  out  8  byte to transmit; held stable until tx_done.
- tx_active  in  1  transmitter busy.
- tx_done  in  1  one-cycle strobe, transmission finished.
- bus_req  out  1  bus request; held until bus_ack.
- bus_we  out  1  1 = write, 0 = read; valid while bus_req.
- bus_addr  out  16  transaction address; valid while bus_req.
- bus_wdata  out  8  write data; valid while bus_req.
- bus_ack  in  1  one-cycle completion strobe from the bus.
- bus_rdata  in  8  read data, sampled in the bus_ack cycle.
- cpu_halt  out  1  1 = CPU/PPU held in reset and bus owned by host.
- err_overrun  out  1  sticky: byte received while busy.
- err_timeout  out  1  sticky: command aborted by timeout.

Behaviour:
- Reset values (rst=0 at a rising clk edge): state IDLE; all outputs 0 except cpu_halt=0.
  - Reset mid-command or mid-bus-cycle drops bus_req on the next edge with no completion.
  - cpu_halt returns to 0 on reset.
- Opcodes, first byte in IDLE:
  - 0x02 WRITE: addr_hi, addr_lo, data follow.
  - 0x03 READ: addr_hi, addr_lo follow; one byte is returned.
  - 0x06 HALT: cpu_halt <= 1.
  - 0x07 RUN: cpu_halt <= 0.
  - Any other byte is ignored and the block stays in IDLE.
- State machine:
  - IDLE -> GET_AH -> GET_AL -> (WRITE) GET_D -> BUS -> IDLE.
  - IDLE -> GET_AH -> GET_AL -> (READ) BUS -> TX_GO -> TX_WAIT -> IDLE.
- BUS state:
  - bus_req asserts the cycle after the last byte's rx_valid.
  - bus_addr, bus_we and bus_wdata are stable for the whole request.
  - bus_req drops the cycle after bus_ack.
  - There is no bus timeout; the bus must eventually ack.
- Halt gating: if cpu_halt=0 when the last byte arrives:
  - WRITE: no bus request is issued; the block returns to IDLE.
  - READ: no bus request is issued; 0xFF is returned.
- TX_GO:
  - Waits for tx_active=0, then pulses tx_start for exactly 1 cycle with tx_data = captured rdata.
  - TX_WAIT then waits for tx_done, then returns to IDLE.
- Overrun: rx_valid in BUS, TX_GO or TX_WAIT:
  - The byte is dropped and err_overrun is set.
  - The current command completes normally.
- Timeout:
  - The counter clears on every rx_valid and counts only in GET_AH, GET_AL and GET_D.
  - At TIMEOUT_CYCLES the block goes to IDLE and sets err_timeout.
  - If rx_valid arrives in the same cycle as expiry, rx_valid wins and the byte is consumed.
- Address assembly: {addr_hi, addr_lo}. No auto-increment. 16-bit address, full range 0x0000-0xFFFF.
- Simultaneous rx_valid and reset: reset wins.

Optional Feature:
- Macro: UART_CMD_ACK_EN.
- Defined: after a WRITE bus_ack (or the gated drop), a HALT or a RUN, the block transmits one ack byte equal to the opcode (0x02, 0x06 or 0x07) via TX_GO/TX_WAIT before returning to IDLE.
- Undefined: only READ produces a UART response.

Test Plan:
- Reset, then send 0x06 -> cpu_halt=1 within 1 cycle of rx_valid; no bus_req.
- Halted; send 0x02,0x80,0x00,0x4C -> exactly one bus_req with we=1, addr=0x8000, wdata=0x4C; bus_req drops the cycle after bus_ack.
- Halted; send 0x03,0x01,0x23 with the bus returning 0x5A -> one read request at addr=0x0123, then one tx_start with tx_data=0x5A.
- cpu_halt=0; send 0x03,0x20,0x07 -> no bus_req; tx_data=0xFF.
- Send 0x02,0x80 then idle TIMEOUT_CYCLES -> err_timeout=1, state IDLE; then send 0x06 -> cpu_halt=1.
- During a READ, hold bus_ack off and inject rx_valid=0x07 -> err_overrun=1; cpu_halt stays 1; the read completes.
